// File: rtl/track_sequencer.sv
// Two-track step sequencer sharing one free-running tempo counter.
// Optional restart-on-play is enabled by defining TRACK_SEQ_RESTART_EN.
module track_sequencer #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] tracks_playing,
  output logic       step_tick,
  output logic [3:0] step0,
  output logic [3:0] step1,
  output logic [3:0] note0,
  output logic [3:0] note1,
  output logic [3:0] mix_note,
  output logic       note_change
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0][3:0]  step_q, step_d;
  logic [1:0][3:0]  note_q, note_d;
  logic [3:0]       mix_q, mix_d;
  logic             change_q;

  function automatic logic [3:0] table0(input logic [3:0] k);
    return {1'b0, k[2:0]} + 4'd1;
  endfunction

  function automatic logic [3:0] table1(input logic [3:0] k);
    return k[0] ? 4'd0 : 4'd9 + {2'b00, k[2:1]};
  endfunction

`ifdef TRACK_SEQ_RESTART_EN
  logic [1:0] play_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_prev_q <= 2'b00;
    end else begin
      play_prev_q <= tracks_playing;
    end
  end
`endif

  assign step_tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = step_tick ? '0 : cnt_q + 1'b1;
    for (int i = 0; i < 2; i++) begin
      step_d[i] = step_q[i];
      if (step_tick && tracks_playing[i]) begin
        step_d[i] = step_q[i] + 4'd1;
      end
`ifdef TRACK_SEQ_RESTART_EN
      // Restart takes priority over a coincident step advance.
      if (tracks_playing[i] && !play_prev_q[i]) begin
        step_d[i] = 4'd0;
      end
`endif
    end
    note_d[0] = tracks_playing[0] ? table0(step_q[0]) : 4'd0;
    note_d[1] = tracks_playing[1] ? table1(step_q[1]) : 4'd0;
    mix_d     = (note_q[1] != 4'd0) ? note_q[1] : note_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      step_q   <= '0;
      note_q   <= '0;
      mix_q    <= 4'd0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      note_q   <= note_d;
      mix_q    <= mix_d;
      change_q <= (mix_d != mix_q);
    end
  end

  assign step0       = step_q[0];
  assign step1       = step_q[1];
  assign note0       = note_q[0];
  assign note1       = note_q[1];
  assign mix_note    = mix_q;
  assign note_change = change_q;

endmodule

// File: tb/tb_track_sequencer.sv
// Bench for track_sequencer at TICK_DIV=4: per-cycle reference model plus directed literals.
module tb_track_sequencer;

  localparam int Div = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] tp = 2'b00;
  logic       step_tick, note_change;
  logic [3:0] step0, step1, note0, note1, mix_note;

  int errors = 0;
  int checks = 0;

  track_sequencer #(.TICK_DIV(Div)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tracks_playing(tp),
    .step_tick     (step_tick),
    .step0         (step0),
    .step1         (step1),
    .note0         (note0),
    .note1         (note1),
    .mix_note      (mix_note),
    .note_change   (note_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: phase within the beat, pattern positions, notes and mix.
  int       m_cnt = 0;
  int       m_step[2] = '{0, 0};
  int       m_note[2] = '{0, 0};
  int       m_mix = 0;
  int       m_chg = 0;
  bit [1:0] m_prev = 2'b00;
  int       nn[2];
  int       nmix;
  bit       mtick;

  function automatic int pattern(input int trk, input int k);
    if (trk == 0) return (k % 8) + 1;
    return (k % 2 == 1) ? 0 : 9 + ((k / 2) % 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_step = '{0, 0}; m_note = '{0, 0};
      m_mix = 0; m_chg = 0; m_prev = 2'b00;
    end else begin
      mtick = (m_cnt == Div - 1);
      for (int i = 0; i < 2; i++) nn[i] = tp[i] ? pattern(i, m_step[i]) : 0;
      nmix  = (m_note[1] != 0) ? m_note[1] : m_note[0];
      m_chg = (nmix != m_mix) ? 1 : 0;
      m_mix = nmix;
      m_note = nn;
      for (int i = 0; i < 2; i++) begin
        if (mtick && tp[i]) m_step[i] = (m_step[i] + 1) % 16;
`ifdef TRACK_SEQ_RESTART_EN
        if (tp[i] && !m_prev[i]) m_step[i] = 0;
`endif
      end
      m_prev = tp;
      m_cnt  = (m_cnt + 1) % Div;
    end
  end

  always @(negedge clk) begin
    check("step_tick", int'(step_tick), (m_cnt == Div - 1) ? 1 : 0);
    check("step0", int'(step0), m_step[0]);
    check("step1", int'(step1), m_step[1]);
    check("note0", int'(note0), m_note[0]);
    check("note1", int'(note1), m_note[1]);
    check("mix_note", int'(mix_note), m_mix);
    check("note_change", int'(note_change), m_chg);
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  // Edges after release until step_tick is seen; the step advances on the following edge.
  task automatic tick_latency(input string nm);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = step_tick;
    end
    check(nm, n, Div - 1);
  endtask

  initial begin
    // Idle after reset: ticks run, nothing plays.
    run(2);
    rst_n = 1'b1;
    tick_latency("first_tick_after_release");
    run(12);
    check("idle_step0", int'(step0), 0);
    check("idle_mix", int'(mix_note), 0);

    // Track one alone for 17 steps wraps to position 1.
    tp = 2'b01;
    do_reset();
    run(68);
    check("wrap_step0", int'(step0), 1);
    check("wrap_step1", int'(step1), 0);
    run(1);
    check("wrap_note0", int'(note0), 2);
    run(1);
    check("wrap_mix", int'(mix_note), 2);

    // Both tracks: track two overrides the mix when non-rest.
    tp = 2'b11;
    do_reset();
    run(9);
    check("both_note1_s2", int'(note1), 10);
    check("both_note0_s2", int'(note0), 3);
    run(1);
    check("both_mix_s2", int'(mix_note), 10);
    run(3);
    check("both_note1_s3", int'(note1), 0);
    run(1);
    check("both_mix_s3", int'(mix_note), 4);
    check("both_change_s3", int'(note_change), 1);

    // Pause and resume.
    tp = 2'b01;
    do_reset();
    run(20);
    check("pause_step0_pre", int'(step0), 5);
    tp = 2'b00;
    run(12);
    check("pause_step0_hold", int'(step0), 5);
    check("pause_note0", int'(note0), 0);
    tp = 2'b01;
    run(1);
`ifdef TRACK_SEQ_RESTART_EN
    check("resume_step0_edge", int'(step0), 0);
    run(3);
    check("resume_step0_tick", int'(step0), 1);
`else
    check("resume_step0_edge", int'(step0), 5);
    run(3);
    check("resume_step0_tick", int'(step0), 6);
`endif

    // Track two rises on the same edge as a step boundary.
    tp = 2'b01;
    do_reset();
    run(3);
    tp = 2'b11;
    run(1);
    check("coincide_step0", int'(step0), 1);
`ifdef TRACK_SEQ_RESTART_EN
    check("coincide_step1", int'(step1), 0);
`else
    check("coincide_step1", int'(step1), 1);
`endif

    // Asynchronous reset mid-step.
    run(6);
    rst_n = 1'b0;
    #1;
    check("async_step0", int'(step0), 0);
    check("async_step1", int'(step1), 0);
    check("async_note0", int'(note0), 0);
    check("async_note1", int'(note1), 0);
    check("async_mix", int'(mix_note), 0);
    check("async_tick", int'(step_tick), 0);
    check("async_change", int'(note_change), 0);
    run(1);
    rst_n = 1'b1;
    tick_latency("tick_after_async_reset");
    run(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
